ccd_frame_capture: RTL and testbench

- Front-end capture stage that sits directly upstream of the camera processing top level.
- Converts raw sensor FVAL/LVAL/pixel data into the frame-aligned stream that the top level consumes: pixel data, data valid, X/Y coordinates and a gated frame-valid.
- Start/stop control is frame-synchronous: only whole frames are ever passed downstream.
- Keeps a running count of completed frames.

---
 rtl/ccd_frame_capture.sv | 153 +++++++++++++++
 tb/tb_ccd_frame_capture.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ccd_frame_capture.sv
// Sensor front end: registers raw FVAL/LVAL/pixel data and passes only whole frames
// downstream, with X/Y pixel coordinates and a count of completed frames.
module ccd_frame_capture #(
    parameter int DATA_W       = 12,
    parameter int COLUMN_WIDTH = 1280,
    parameter int CNT_W        = 16
) (
    input  logic              iClk,
    input  logic              iRst_n,
    input  logic              iStart,
    input  logic              iEnd,
    input  logic              iFVAL,
    input  logic              iLVAL,
    input  logic [DATA_W-1:0] iDATA,
    output logic [DATA_W-1:0] oDATA,
    output logic              oDVAL,
    output logic [CNT_W-1:0]  oX_Cont,
    output logic [CNT_W-1:0]  oY_Cont,
    output logic              oFval,
    output logic [31:0]       oFrame_Cont,
    output logic              oBusy
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARMED   = 2'd1,
        S_CAPTURE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_stop_pending;
    logic               w_stop_nxt;
    logic               w_fval_nxt;

    logic               r_fval;
    logic               r_fval_d;
    logic               r_lval;
    logic [DATA_W-1:0]  r_data;
    logic [CNT_W-1:0]   r_x_cnt;
    logic [CNT_W-1:0]   r_y_cnt;

    logic               w_fs;
    logic               w_fe;
    logic               w_in_frame;
    logic               w_pix_valid;

    assign w_fs        = r_fval & ~r_fval_d;
    assign w_fe        = ~r_fval & r_fval_d;
    assign w_in_frame  = (r_state == S_CAPTURE) & r_fval;
    assign w_pix_valid = w_in_frame & r_lval;
    assign oBusy       = (r_state != S_IDLE);

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            r_fval   <= 1'b0;
            r_fval_d <= 1'b0;
            r_lval   <= 1'b0;
            r_data   <= '0;
        end else begin
            r_fval   <= iFVAL;
            r_fval_d <= r_fval;
            r_lval   <= iLVAL;
            r_data   <= iDATA;
        end
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            r_state        <= S_IDLE;
            r_stop_pending <= 1'b0;
            oFval          <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_stop_pending <= w_stop_nxt;
            oFval          <= w_fval_nxt;
        end
    end

    // A stop request waits for the end of the current frame; iEnd beats iStart.
    always_comb begin
        w_state_nxt = r_state;
        w_stop_nxt  = r_stop_pending;
        w_fval_nxt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (iStart && !iEnd) w_state_nxt = S_ARMED;
            end
            S_ARMED: begin
                if (iEnd) begin
                    w_state_nxt = S_IDLE;
                end else if (w_fs) begin
                    w_state_nxt = S_CAPTURE;
                    w_fval_nxt  = 1'b1;
                end
            end
            S_CAPTURE: begin
                w_fval_nxt = r_fval;
                if (iEnd) w_stop_nxt = 1'b1;
                if (w_fe && (r_stop_pending || iEnd)) begin
                    w_state_nxt = S_IDLE;
                    w_stop_nxt  = 1'b0;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_stop_nxt  = 1'b0;
            end
        endcase
    end

    // r_x_cnt/r_y_cnt hold the coordinate the next valid pixel will receive.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            r_x_cnt <= '0;
            r_y_cnt <= '0;
            oX_Cont <= '0;
            oY_Cont <= '0;
            oDVAL   <= 1'b0;
            oDATA   <= '0;
        end else if (!w_in_frame) begin
            r_x_cnt <= '0;
            r_y_cnt <= '0;
            oX_Cont <= '0;
            oY_Cont <= '0;
            oDVAL   <= 1'b0;
            oDATA   <= '0;
        end else if (w_pix_valid) begin
            oX_Cont <= r_x_cnt;
            oY_Cont <= r_y_cnt;
            oDVAL   <= 1'b1;
            oDATA   <= r_data;
            if (r_x_cnt == CNT_W'(COLUMN_WIDTH - 1)) begin
                r_x_cnt <= '0;
                r_y_cnt <= r_y_cnt + 1'b1;
            end else begin
                r_x_cnt <= r_x_cnt + 1'b1;
            end
        end else begin
            oDVAL <= 1'b0;
            oDATA <= '0;
        end
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            oFrame_Cont <= '0;
        end else if ((r_state == S_CAPTURE) && w_fe) begin
            oFrame_Cont <= oFrame_Cont + 32'd1;
        end
    end

endmodule

// File: tb/tb_ccd_frame_capture.sv
// Directed bench for ccd_frame_capture with a 4-pixel row: expected pixels are queued
// as they are driven and a negedge monitor pops and compares them.
module tb_ccd_frame_capture;

    localparam int DATA_W = 12;
    localparam int COL_W  = 4;
    localparam int CNT_W  = 16;
    localparam int EXP_W  = DATA_W + 2 * CNT_W;

    logic              iClk = 1'b0;
    logic              iRst_n;
    logic              iStart;
    logic              iEnd;
    logic              iFVAL;
    logic              iLVAL;
    logic [DATA_W-1:0] iDATA;
    logic [DATA_W-1:0] oDATA;
    logic              oDVAL;
    logic [CNT_W-1:0]  oX_Cont;
    logic [CNT_W-1:0]  oY_Cont;
    logic              oFval;
    logic [31:0]       oFrame_Cont;
    logic              oBusy;

    logic [EXP_W-1:0]  exp_q[$];
    int                exp_t_q[$];
    int                cyc_n = 0;
    int                n_checks = 0;
    int                n_fail = 0;
    int                m_x;
    int                m_y;

    ccd_frame_capture #(
        .DATA_W      (DATA_W),
        .COLUMN_WIDTH(COL_W),
        .CNT_W       (CNT_W)
    ) dut (
        .iClk       (iClk),
        .iRst_n     (iRst_n),
        .iStart     (iStart),
        .iEnd       (iEnd),
        .iFVAL      (iFVAL),
        .iLVAL      (iLVAL),
        .iDATA      (iDATA),
        .oDATA      (oDATA),
        .oDVAL      (oDVAL),
        .oX_Cont    (oX_Cont),
        .oY_Cont    (oY_Cont),
        .oFval      (oFval),
        .oFrame_Cont(oFrame_Cont),
        .oBusy      (oBusy)
    );

    always #5 iClk = ~iClk;
    always @(posedge iClk) cyc_n = cyc_n + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks = n_checks + 1;
        if (act !== req) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Scoreboard monitor: every presented pixel must match the head of the queue.
    always @(negedge iClk) begin
        if (iRst_n) begin
            if (oDVAL) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_dval", {32'd0, oX_Cont, oY_Cont}, 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    logic [EXP_W-1:0] e;
                    int               t;
                    e = exp_q.pop_front();
                    t = exp_t_q.pop_front();
                    chk("pix_data", 64'(oDATA), 64'(e[EXP_W-1 -: DATA_W]));
                    chk("pix_y", 64'(oY_Cont), 64'(e[2*CNT_W-1 -: CNT_W]));
                    chk("pix_x", 64'(oX_Cont), 64'(e[CNT_W-1:0]));
                    chk("pix_latency", 64'(cyc_n), 64'(t));
                end
            end else begin
                chk("data_zero_when_invalid", 64'(oDATA), 64'd0);
            end
        end
    end

    task automatic cyc();
        @(posedge iClk);
        #1;
    endtask

    task automatic idle(input int n);
        iFVAL = 1'b0; iLVAL = 1'b0; iDATA = '0; iStart = 1'b0; iEnd = 1'b0;
        repeat (n) cyc();
    endtask

    task automatic pulse_reset();
        iRst_n = 1'b0;
        idle(2);
        iRst_n = 1'b1;
        cyc();
    endtask

    task automatic start_pulse();
        iStart = 1'b1;
        cyc();
        iStart = 1'b0;
    endtask

    task automatic push_pix(input int data);
        exp_q.push_back({DATA_W'(data), CNT_W'(m_y), CNT_W'(m_x)});
        exp_t_q.push_back(cyc_n + 2);
        m_x = m_x + 1;
        if (m_x == COL_W) begin
            m_x = 0;
            m_y = m_y + 1;
        end
    endtask

    // One frame: FVAL leads LVAL by two cycles; gap_at inserts a 3-cycle LVAL gap inside each line.
    task automatic send_frame(input int lines, input int ppl, input int base, input bit exp_on,
                              input int gap_at, input int start_at, input int end_at);
        int p;
        p = 0; m_x = 0; m_y = 0;
        iFVAL = 1'b1; iLVAL = 1'b0; iDATA = '0;
        cyc(); cyc();
        for (int l = 0; l < lines; l++) begin
            for (int i = 0; i < ppl; i++) begin
                if (i == gap_at && i != 0) begin
                    iLVAL = 1'b0; iDATA = '0;
                    repeat (3) cyc();
                end
                iLVAL  = 1'b1;
                iDATA  = DATA_W'(base + p);
                iStart = (p == start_at);
                iEnd   = (p == end_at);
                if (exp_on) push_pix(base + p);
                p = p + 1;
                cyc();
                iStart = 1'b0; iEnd = 1'b0;
            end
            iLVAL = 1'b0; iDATA = '0;
            cyc(); cyc();
        end
        iFVAL = 1'b0;
        cyc();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: actual=running required=finished");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "timeout");
    end

    initial begin
        // Reset with junk on every input.
        iRst_n = 1'b0; iStart = 1'b1; iEnd = 1'b0;
        iFVAL = 1'b1; iLVAL = 1'b1; iDATA = 12'hABC;
        repeat (3) @(negedge iClk);
        chk("rst_odata", 64'(oDATA), 64'd0);
        chk("rst_odval", 64'(oDVAL), 64'd0);
        chk("rst_x", 64'(oX_Cont), 64'd0);
        chk("rst_y", 64'(oY_Cont), 64'd0);
        chk("rst_ofval", 64'(oFval), 64'd0);
        chk("rst_frames", 64'(oFrame_Cont), 64'd0);
        chk("rst_busy", 64'(oBusy), 64'd0);
        @(posedge iClk); #1;
        idle(1);
        iRst_n = 1'b1;
        idle(2);

        // No iStart: sensor activity must not reach the output.
        send_frame(2, 4, 100, 1'b0, -1, -1, -1);
        idle(3);
        @(negedge iClk);
        chk("nostart_frames", 64'(oFrame_Cont), 64'd0);
        chk("nostart_busy", 64'(oBusy), 64'd0);

        // Aligned start: 2 lines x 4 pixels, data 1..8.
        @(posedge iClk); #1;
        start_pulse();
        idle(1);
        @(negedge iClk);
        chk("armed_busy", 64'(oBusy), 64'd1);
        chk("armed_ofval", 64'(oFval), 64'd0);
        @(posedge iClk); #1;
        send_frame(2, 4, 1, 1'b1, -1, -1, -1);
        idle(3);
        @(negedge iClk);
        chk("aligned_frames", 64'(oFrame_Cont), 64'd1);

        // Mid-frame start: that frame is skipped, the next one captured.
        @(posedge iClk); #1;
        pulse_reset();
        send_frame(2, 4, 40, 1'b0, -1, 2, -1);
        idle(3);
        send_frame(2, 4, 60, 1'b1, -1, -1, -1);
        idle(3);
        @(negedge iClk);
        chk("midstart_frames", 64'(oFrame_Cont), 64'd1);
        chk("midstart_busy", 64'(oBusy), 64'd1);

        // Stop during frame 3: frame 3 completes, frame 4 is dropped.
        @(posedge iClk); #1;
        pulse_reset();
        start_pulse();
        idle(2);
        send_frame(1, 4, 10, 1'b1, -1, -1, -1);
        idle(3);
        send_frame(1, 4, 20, 1'b1, -1, -1, -1);
        idle(3);
        send_frame(2, 4, 30, 1'b1, -1, -1, 3);
        @(negedge iClk);
        chk("stop_busy_at_fe", 64'(oBusy), 64'd1);
        chk("stop_frames_at_fe", 64'(oFrame_Cont), 64'd2);
        @(negedge iClk);
        chk("stop_busy_after_fe", 64'(oBusy), 64'd0);
        chk("stop_frames", 64'(oFrame_Cont), 64'd3);
        @(posedge iClk); #1;
        iStart = 1'b1; iEnd = 1'b1;
        cyc();
        iStart = 1'b0; iEnd = 1'b0;
        idle(1);
        @(negedge iClk);
        chk("start_end_same_cycle_busy", 64'(oBusy), 64'd0);
        @(posedge iClk); #1;
        send_frame(2, 4, 90, 1'b0, -1, -1, -1);
        idle(3);
        @(negedge iClk);
        chk("frame4_frames", 64'(oFrame_Cont), 64'd3);

        // Coordinate wrap: 12 contiguous pixels, then a row with a 3-cycle LVAL gap.
        @(posedge iClk); #1;
        pulse_reset();
        start_pulse();
        idle(2);
        send_frame(1, 12, 200, 1'b1, -1, -1, -1);
        idle(3);
        send_frame(1, 8, 300, 1'b1, 2, -1, -1);
        idle(3);
        @(negedge iClk);
        chk("wrap_frames", 64'(oFrame_Cont), 64'd2);

        // Async reset in the middle of line 1.
        @(posedge iClk); #1;
        pulse_reset();
        start_pulse();
        iFVAL = 1'b1;
        cyc(); cyc();
        iLVAL = 1'b1;
        iDATA = 12'h055; m_x = 0; m_y = 0; push_pix(12'h055);
        cyc();
        iDATA = 12'h056;
        cyc();
        iDATA = 12'h057;
        cyc();
        iRst_n = 1'b0;
        #1;
        chk("async_odval", 64'(oDVAL), 64'd0);
        chk("async_odata", 64'(oDATA), 64'd0);
        chk("async_ofval", 64'(oFval), 64'd0);
        chk("async_busy", 64'(oBusy), 64'd0);
        chk("async_x", 64'(oX_Cont), 64'd0);
        idle(2);
        iRst_n = 1'b1;
        idle(2);
        send_frame(2, 4, 500, 1'b0, -1, -1, -1);
        idle(3);
        send_frame(1, 4, 600, 1'b0, -1, -1, -1);
        idle(3);
        @(negedge iClk);
        chk("post_reset_frames", 64'(oFrame_Cont), 64'd0);
        chk("post_reset_busy", 64'(oBusy), 64'd0);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
